regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: ALU/link results and load data from the LSU.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards.
- Drives the register-file write code, address and data from registered outputs. The register file commits these on the following negedge.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/regfile_wb_arbiter_if.sv | 38 +++
 rtl/wb_hold_buf.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 114 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared writeback types and constants for the register-file write-port arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package wb_pkg;

  localparam int REG_IDX_W = 5;
  localparam int WB_DATA_W = 32;

  // Register-file write codes
  localparam logic [1:0] RF_WR_NONE = 2'b00;
  localparam logic [1:0] RF_WR_RT   = 2'b10;
  localparam logic [1:0] RF_WR_R31  = 2'b11;

  localparam logic [REG_IDX_W-1:0] LINK_REG = 5'd31;

  // One writeback request as held in a holding buffer
  typedef struct packed {
    logic [REG_IDX_W-1:0] dst;
    logic [WB_DATA_W-1:0] data;
    logic                 link;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request channels (ALU, LSU) and the registered register-file write bus.
// Latency: none (wiring only).
// Backpressure: ready per requester reflects its holding buffer being empty.
interface regfile_wb_arbiter_if;
  import wb_pkg::*;

  logic                 alu_valid;
  logic                 alu_ready;
  logic                 alu_link;
  logic [REG_IDX_W-1:0] alu_dst;
  logic [WB_DATA_W-1:0] alu_data;

  logic                 ld_valid;
  logic                 ld_ready;
  logic [REG_IDX_W-1:0] ld_dst;
  logic [WB_DATA_W-1:0] ld_data;

  logic [1:0]           rf_reg_write;
  logic [REG_IDX_W-1:0] rf_addr;
  logic [WB_DATA_W-1:0] rf_data;

  // Requester side: drives requests, observes ready and the write bus
  modport master (
    output alu_valid, alu_link, alu_dst, alu_data,
    output ld_valid, ld_dst, ld_data,
    input  alu_ready, ld_ready,
    input  rf_reg_write, rf_addr, rf_data
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_link, alu_dst, alu_data,
    input  ld_valid, ld_dst, ld_data,
    output alu_ready, ld_ready,
    output rf_reg_write, rf_addr, rf_data
  );

endinterface

// File: rtl/wb_hold_buf.sv
// One-entry valid/ready holding buffer for a writeback request.
// Latency: request captured at the accepting edge, visible as held the cycle after.
// Backpressure: ready = buffer empty; a granted entry frees the slot for the next edge.
module wb_hold_buf
  import wb_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req_valid,
  output logic    req_ready,
  input  wb_req_t req,
  output logic    held_valid,
  output wb_req_t held,
  input  logic    grant
);

  assign req_ready = !held_valid;

  // Capture when empty, release on grant; ready is low while full so both never coincide
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_valid <= 1'b0;
      held       <= '0;
    end else if (req_valid && !held_valid) begin
      held_valid <= 1'b1;
      held       <= req;
    end else if (grant) begin
      held_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU/link and load writebacks onto the single register-file write port and
// tracks pending writes per register for RAW stalls; grant to rf outputs is 1 cycle after accept.
// Backpressure: per-requester one-entry buffer; issue stalls when a pending counter saturates.
// Optional: define WB_RR_EN for round-robin arbitration (default is fixed LSU-over-ALU).
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = WB_DATA_W,
  parameter int CNT_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iss_valid,
  input  logic [REG_IDX_W-1:0] iss_dst,
  output logic                 iss_ready,
  input  logic [REG_IDX_W-1:0] src1,
  input  logic [REG_IDX_W-1:0] src2,
  output logic                 hazard,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  wb_req_t alu_req, ld_req, alu_held, ld_held, win;
  logic    alu_occ, ld_occ, grant_alu, grant_ld, any_grant;
  logic [REG_IDX_W-1:0] win_addr;
  logic [DATA_W-1:0]    win_data;
  logic [CNT_W-1:0]     cnt [NUM_REGS];
  logic [NUM_REGS-1:0]  inc_vec, dec_vec;

  assign alu_req = {bus.alu_dst, bus.alu_data, bus.alu_link};
  assign ld_req  = {bus.ld_dst, bus.ld_data, 1'b0};

  wb_hold_buf u_alu_buf (
    .clk(clk), .rst_n(rst_n),
    .req_valid(bus.alu_valid), .req_ready(bus.alu_ready), .req(alu_req),
    .held_valid(alu_occ), .held(alu_held), .grant(grant_alu)
  );

  wb_hold_buf u_ld_buf (
    .clk(clk), .rst_n(rst_n),
    .req_valid(bus.ld_valid), .req_ready(bus.ld_ready), .req(ld_req),
    .held_valid(ld_occ), .held(ld_held), .grant(grant_ld)
  );

`ifdef WB_RR_EN
  logic prio_ld;

  // Hand priority to the loser after every contended grant
  always_ff @(posedge clk) begin
    if (!rst_n) prio_ld <= 1'b1;
    else if (ld_occ && alu_occ) prio_ld <= !prio_ld;
  end
`endif

  // Pick the winner among occupied buffers
  always_comb begin
    grant_ld  = ld_occ;
    grant_alu = alu_occ && !ld_occ;
`ifdef WB_RR_EN
    if (ld_occ && alu_occ) begin
      grant_ld  = prio_ld;
      grant_alu = !prio_ld;
    end
`endif
    win = grant_ld ? ld_held : alu_held;
  end

  assign any_grant = ld_occ || alu_occ;
  assign win_addr  = win.link ? LINK_REG : win.dst;
  assign win_data  = win.data;

  // Registered write bus; addr/data hold when idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rf_reg_write <= RF_WR_NONE;
      bus.rf_addr      <= '0;
      bus.rf_data      <= '0;
    end else if (any_grant) begin
      bus.rf_reg_write <= win.link ? RF_WR_R31 : RF_WR_RT;
      bus.rf_addr      <= win_addr;
      bus.rf_data      <= win_data;
    end else begin
      bus.rf_reg_write <= RF_WR_NONE;
    end
  end

  assign iss_ready = (cnt[iss_dst] != CNT_MAX);
  assign hazard    = (|cnt[src1]) || (|cnt[src2]);

  // Per-register increment/decrement requests; decrement of an idle counter is ignored
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc_vec[i] = iss_valid && iss_ready && (iss_dst == REG_IDX_W'(i));
      dec_vec[i] = any_grant && (win_addr == REG_IDX_W'(i)) && (cnt[i] != '0);
    end
  end

  // Pending-write scoreboard; simultaneous inc and dec cancel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (inc_vec[i] && !dec_vec[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (dec_vec[i] && !inc_vec[i]) cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the writeback arbiter: reset, single write, contention, link,
// saturation with simultaneous issue/grant, and reset with both buffers full.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_regfile_wb_arbiter;
  import wb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iss_valid;
  logic [4:0] iss_dst;
  logic       iss_ready;
  logic [4:0] src1, src2;
  logic       hazard;
  int         checks = 0;
  int         errors = 0;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_ready(iss_ready),
    .src1(src1), .src2(src2), .hazard(hazard),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] d);
    iss_valid = 1'b1;
    iss_dst   = d;
    step();
    iss_valid = 1'b0;
  endtask

  task automatic chk_rf(input string tag, input logic [1:0] code, input logic [4:0] a,
                        input logic [31:0] d);
    chk({tag, "_code"}, 32'(bus.rf_reg_write), 32'(code));
    chk({tag, "_addr"}, 32'(bus.rf_addr), 32'(a));
    chk({tag, "_data"}, bus.rf_data, d);
  endtask

  initial begin
    rst_n = 1'b0; iss_valid = 1'b0; iss_dst = '0; src1 = '0; src2 = '0;
    bus.alu_valid = 1'b0; bus.alu_link = 1'b0; bus.alu_dst = '0; bus.alu_data = '0;
    bus.ld_valid = 1'b0; bus.ld_dst = '0; bus.ld_data = '0;

    // 1. reset then idle
    step();
    chk_rf("rst", RF_WR_NONE, 5'd0, 32'h0);
    chk("rst_hazard", 32'(hazard), 32'd0);
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("rst_iss_ready", 32'(iss_ready), 32'd1);
    rst_n = 1'b1;
    step();
    chk("idle_code", 32'(bus.rf_reg_write), 32'(RF_WR_NONE));

    // 2. single ALU write to r5
    src1 = 5'd5; src2 = 5'd0;
    issue(5'd5);
    chk("alu_hazard_issued", 32'(hazard), 32'd1);
    bus.alu_valid = 1'b1; bus.alu_dst = 5'd5; bus.alu_data = 32'hDEADBEEF;
    step();
    bus.alu_valid = 1'b0;
    chk("alu_ready_full", 32'(bus.alu_ready), 32'd0);
    chk("alu_hazard_held", 32'(hazard), 32'd1);
    chk("alu_no_write_yet", 32'(bus.rf_reg_write), 32'(RF_WR_NONE));
    step();
    chk_rf("alu_wr", RF_WR_RT, 5'd5, 32'hDEADBEEF);
    chk("alu_hazard_clear", 32'(hazard), 32'd0);
    chk("alu_ready_refill", 32'(bus.alu_ready), 32'd1);
    step();
    chk_rf("alu_idle_hold", RF_WR_NONE, 5'd5, 32'hDEADBEEF);

    // 3. contention, two rounds
    issue(5'd3);
    issue(5'd4);
    bus.ld_valid = 1'b1; bus.ld_dst = 5'd3; bus.ld_data = 32'h11;
    bus.alu_valid = 1'b1; bus.alu_dst = 5'd4; bus.alu_data = 32'h22;
    step();
    bus.ld_valid = 1'b0; bus.alu_valid = 1'b0;
    chk("c1_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("c1_alu_ready", 32'(bus.alu_ready), 32'd0);
    step();
    chk_rf("c1_first", RF_WR_RT, 5'd3, 32'h11);
    chk("c1_alu_waiting", 32'(bus.alu_ready), 32'd0);
    step();
    chk_rf("c1_second", RF_WR_RT, 5'd4, 32'h22);
    src1 = 5'd3; src2 = 5'd4; #1;
    chk("c1_hazard_clear", 32'(hazard), 32'd0);
    issue(5'd3);
    issue(5'd4);
    bus.ld_valid = 1'b1; bus.ld_dst = 5'd3; bus.ld_data = 32'h33;
    bus.alu_valid = 1'b1; bus.alu_dst = 5'd4; bus.alu_data = 32'h44;
    step();
    bus.ld_valid = 1'b0; bus.alu_valid = 1'b0;
    step();
`ifdef WB_RR_EN
    chk_rf("c2_first", RF_WR_RT, 5'd4, 32'h44);
    step();
    chk_rf("c2_second", RF_WR_RT, 5'd3, 32'h33);
`else
    chk_rf("c2_first", RF_WR_RT, 5'd3, 32'h33);
    step();
    chk_rf("c2_second", RF_WR_RT, 5'd4, 32'h44);
`endif
    step();
    chk("c2_idle", 32'(bus.rf_reg_write), 32'(RF_WR_NONE));

    // 4. link write: goes to r31, leaves r7 pending
    issue(5'd31);
    issue(5'd7);
    bus.alu_valid = 1'b1; bus.alu_link = 1'b1; bus.alu_dst = 5'd7; bus.alu_data = 32'h400;
    step();
    bus.alu_valid = 1'b0; bus.alu_link = 1'b0;
    step();
    chk_rf("link", RF_WR_R31, 5'd31, 32'h400);
    src1 = 5'd31; src2 = 5'd31; #1;
    chk("link_r31_clear", 32'(hazard), 32'd0);
    src1 = 5'd7; #1;
    chk("link_r7_pending", 32'(hazard), 32'd1);

    // 5. saturation on r9
    issue(5'd9);
    issue(5'd9);
    issue(5'd9);
    iss_dst = 5'd9; #1;
    chk("sat_ready_r9", 32'(iss_ready), 32'd0);
    iss_dst = 5'd10; #1;
    chk("sat_ready_r10", 32'(iss_ready), 32'd1);
    bus.ld_valid = 1'b1; bus.ld_dst = 5'd9; bus.ld_data = 32'h99;
    step();
    bus.ld_valid = 1'b0;
    step();
    chk_rf("sat_wr1", RF_WR_RT, 5'd9, 32'h99);
    iss_dst = 5'd9; #1;
    chk("sat_ready_after_dec", 32'(iss_ready), 32'd1);
    bus.ld_valid = 1'b1; bus.ld_data = 32'h9A;
    step();
    bus.ld_valid = 1'b0;
    issue(5'd9);
    chk_rf("sat_wr2", RF_WR_RT, 5'd9, 32'h9A);
    iss_dst = 5'd9; #1;
    chk("sat_inc_dec_cancel", 32'(iss_ready), 32'd1);
    issue(5'd9);
    iss_dst = 5'd9; #1;
    chk("sat_again", 32'(iss_ready), 32'd0);

    // 6. reset with both buffers full
    bus.ld_valid = 1'b1; bus.ld_dst = 5'd9; bus.ld_data = 32'hAA;
    bus.alu_valid = 1'b1; bus.alu_dst = 5'd7; bus.alu_data = 32'hBB;
    step();
    bus.ld_valid = 1'b0; bus.alu_valid = 1'b0;
    chk("mid_full_ld", 32'(bus.ld_ready), 32'd0);
    chk("mid_full_alu", 32'(bus.alu_ready), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("mid_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk_rf("mid_rst", RF_WR_NONE, 5'd0, 32'h0);
    src1 = 5'd9; src2 = 5'd7; #1;
    chk("mid_hazard", 32'(hazard), 32'd0);
    iss_dst = 5'd9; #1;
    chk("mid_iss_ready", 32'(iss_ready), 32'd1);
    step();
    chk("mid_no_write", 32'(bus.rf_reg_write), 32'(RF_WR_NONE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
